// File: rtl/mips_mainfsm.sv
// mips_mainfsm -- multi-cycle MIPS main controller.
//
// A Moore FSM that sequences each instruction through fetch, decode,
// execute, memory and writeback, driving the datapath mux selects and
// write enables. Fetch (FETCH) and data accesses (MEMRD, MEMWR) wait on
// a memready handshake and can optionally be aborted by a wait timeout.
//
// Handshake: memready is sampled only in FETCH, MEMRD and MEMWR. A high
// memready in one of those states means the memory finishes the access
// in the current cycle, and the FSM leaves the state on the next rising
// edge. While memready is low, the FSM holds the state and keeps driving
// the access controls.
//
// Parameters:
//   MEM_WAIT_MAX  0 disables the timeout. Otherwise, the MEM_WAIT_MAX-th
//                 consecutive stalled cycle in a waiting state pulses
//                 memtimeout, gates off every enable for that cycle, and
//                 returns to FETCH.
//
// Build option:
//   MAINFSM_BNE_EN  When defined, op 000101 (bne) runs through BRANCH
//                   with branchne=1 and branch=0. When undefined, that
//                   opcode is illegal and branchne is tied 0.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   op[5:0]     in   instr[31:26], held stable from DECODE onward
//   memready    in   memory completes the current access this cycle
//   memtoreg    out  writeback data select (1 = memory data)
//   regdst      out  destination register select (1 = rd)
//   iord        out  memory address select (1 = ALUOut)
//   pcsrc[1:0]  out  00 ALUResult, 01 ALUOut, 10 jump target
//   alusrca     out  0 = PC, 1 = A
//   alusrcb[1:0] out 00 B, 01 const 4, 10 SignImm, 11 SignImm<<2
//   aluop[1:0]  out  00 add, 01 sub, 10 use funct
//   irwrite     out  instruction register load enable
//   memwrite    out  data memory write enable
//   pcwrite     out  unconditional PC write enable
//   branch      out  beq qualifier
//   branchne    out  bne qualifier
//   regwrite    out  register file write enable
//   illegalop   out  one-cycle pulse in DECODE on an unsupported opcode
//   memtimeout  out  one-cycle pulse on a timeout abort
//   state[3:0]  out  current state encoding, for debug

module mips_mainfsm #(
    parameter int MEM_WAIT_MAX = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       memready,
    output logic       memtoreg,
    output logic       regdst,
    output logic       iord,
    output logic [1:0] pcsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic       irwrite,
    output logic       memwrite,
    output logic       pcwrite,
    output logic       branch,
    output logic       branchne,
    output logic       regwrite,
    output logic       illegalop,
    output logic       memtimeout,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // The wait counter holds the number of stalled cycles already spent in
    // the current waiting state. It never needs to exceed MEM_WAIT_MAX-1,
    // because the cycle that would reach MEM_WAIT_MAX is the abort cycle.
    localparam int CW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
    localparam logic [CW-1:0] WAIT_LIMIT =
        CW'((MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0);

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] wait_q;
    logic [CW-1:0] wait_d;
    logic          wait_state;
    logic          timeout;
    logic          op_legal;

    assign state = state_q;

    // ------------------------------------------------------------------
    // Opcode classification, shared by the next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        op_legal = 1'b0;
        case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
`ifdef MAINFSM_BNE_EN
            OP_BNE:                                        op_legal = 1'b1;
`endif
            default:                                       op_legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Memory wait timeout
    // ------------------------------------------------------------------
    assign wait_state = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                        (state_q == S_MEMWR);

    // memready on the limit cycle completes the access normally.
    assign timeout = (MEM_WAIT_MAX != 0) && wait_state && !memready &&
                     (wait_q == WAIT_LIMIT);

    // ------------------------------------------------------------------
    // Process 1: state register and wait counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // ------------------------------------------------------------------
    // Process 2: next-state logic (state and wait counter)
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (memready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
`ifdef MAINFSM_BNE_EN
                    OP_BNE:       state_d = S_BRANCH;
`endif
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            // op is still the lw/sw opcode latched in the IR.
            S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:    if (memready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWR:    if (memready) state_d = S_FETCH;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_ADDIEXEC: state_d = S_ADDIWB;
            S_ADDIWB:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            default:    state_d = S_FETCH;   // unused codes 12..15
        endcase

        if (timeout) begin
            state_d = S_FETCH;
        end

        // The counter clears on every state change and on an abort. An abort
        // in FETCH stays in FETCH, so it also clears the counter, which makes
        // the stall count restart. The counter advances only while stalled.
        wait_d = wait_q;
        if (!wait_state || (state_d != state_q) || timeout) begin
            wait_d = '0;
        end else if ((MEM_WAIT_MAX != 0) && !memready) begin
            wait_d = wait_q + CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Process 3: Moore outputs, plus FETCH's memready-qualified enables
    // ------------------------------------------------------------------
    always_comb begin
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        iord       = 1'b0;
        pcsrc      = 2'b00;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        aluop      = 2'b00;
        irwrite    = 1'b0;
        memwrite   = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        branchne   = 1'b0;
        regwrite   = 1'b0;
        illegalop  = 1'b0;
        memtimeout = 1'b0;

        case (state_q)
            S_FETCH: begin
                alusrcb = 2'b01;
                aluop   = 2'b00;
                irwrite = memready;
                pcwrite = memready;
            end
            S_DECODE: begin
                alusrcb   = 2'b11;
                aluop     = 2'b00;
                illegalop = !op_legal;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                iord = 1'b1;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                alusrcb = 2'b00;
                aluop   = 2'b10;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                alusrcb = 2'b00;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
`ifdef MAINFSM_BNE_EN
                // op still holds the branch opcode, so it selects the sense.
                branchne = (op == OP_BNE);
                branch   = (op != OP_BNE);
`else
                branch   = 1'b1;
`endif
            end
            S_ADDIEXEC: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
            end
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;   // unused codes drive all zeros
        endcase

        // Enables are gated off while reset is low, which blocks partial
        // writes when reset hits mid-instruction, and also on the abort cycle.
        if (!reset || timeout) begin
            irwrite   = 1'b0;
            memwrite  = 1'b0;
            pcwrite   = 1'b0;
            branch    = 1'b0;
            branchne  = 1'b0;
            regwrite  = 1'b0;
            illegalop = 1'b0;
        end
        memtimeout = reset && timeout;
    end

endmodule

// File: tb/tb_mips_mainfsm.sv
// tb_mips_mainfsm -- directed, table-driven bench for mips_mainfsm.
// The table entries are per-cycle records. Inputs are driven on the falling
// edge, and the outputs are compared 1 ns later. Hand-written sequences
// cover an asynchronous reset that lands mid-cycle during a store.

module tb_mips_mainfsm;

    localparam logic [5:0] RT  = 6'b000000;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101;
    localparam logic [5:0] ADI = 6'b001000;
    localparam logic [5:0] JMP = 6'b000010;
    localparam logic [5:0] ILL = 6'b111111;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       memready;

    always #5 clk = ~clk;

    logic       memtoreg, regdst, iord, alusrca, irwrite, memwrite, pcwrite;
    logic       branch, branchne, regwrite, illegalop, memtimeout;
    logic [1:0] pcsrc, alusrcb, aluop;
    logic [3:0] state;

    mips_mainfsm #(.MEM_WAIT_MAX(4)) dut (
        .clk(clk), .reset(reset), .op(op), .memready(memready),
        .memtoreg(memtoreg), .regdst(regdst), .iord(iord), .pcsrc(pcsrc),
        .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
        .irwrite(irwrite), .memwrite(memwrite), .pcwrite(pcwrite),
        .branch(branch), .branchne(branchne), .regwrite(regwrite),
        .illegalop(illegalop), .memtimeout(memtimeout), .state(state)
    );

    // Control word layout:
    // {memtoreg, regdst, iord, pcsrc, alusrca, alusrcb, aluop,
    //  irwrite, memwrite, pcwrite, branch, branchne, regwrite, illegalop, memtimeout}
    logic [17:0] act_ctl;
    assign act_ctl = {memtoreg, regdst, iord, pcsrc, alusrca, alusrcb, aluop,
                      irwrite, memwrite, pcwrite, branch, branchne, regwrite,
                      illegalop, memtimeout};

    function automatic logic [17:0] cw(
        input logic m2r, input logic rd, input logic ird, input logic [1:0] pcs,
        input logic asa, input logic [1:0] asb, input logic [1:0] aop,
        input logic irw, input logic mw, input logic pcw, input logic br,
        input logic bn, input logic rw, input logic ill, input logic to);
        return {m2r, rd, ird, pcs, asa, asb, aop, irw, mw, pcw, br, bn, rw, ill, to};
    endfunction

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        mr;
        logic [3:0]  st;
        logic [17:0] ctl;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [5:0] o, input logic m,
                       input logic [3:0] s, input logic [17:0] c);
        vec_t v;
        v.rst = r; v.op = o; v.mr = m; v.st = s; v.ctl = c;
        vecs.push_back(v);
    endtask

    logic [17:0] c_f0, c_fr, c_fto, c_dec, c_deci, c_ma, c_mrd, c_mwb, c_mwr;
    logic [17:0] c_mwto, c_exe, c_awb, c_br, c_bn, c_ae, c_aw, c_j;

    initial begin
        reset    = 1'b0;
        op       = RT;
        memready = 1'b0;

        // Expected control words, transcribed state by state.
        c_f0   = cw(0,0,0,2'b00,0,2'b01,2'b00, 0,0,0,0,0,0,0,0);
        c_fr   = cw(0,0,0,2'b00,0,2'b01,2'b00, 1,0,1,0,0,0,0,0);
        c_fto  = cw(0,0,0,2'b00,0,2'b01,2'b00, 0,0,0,0,0,0,0,1);
        c_dec  = cw(0,0,0,2'b00,0,2'b11,2'b00, 0,0,0,0,0,0,0,0);
        c_deci = cw(0,0,0,2'b00,0,2'b11,2'b00, 0,0,0,0,0,0,1,0);
        c_ma   = cw(0,0,0,2'b00,1,2'b10,2'b00, 0,0,0,0,0,0,0,0);
        c_mrd  = cw(0,0,1,2'b00,0,2'b00,2'b00, 0,0,0,0,0,0,0,0);
        c_mwb  = cw(1,0,0,2'b00,0,2'b00,2'b00, 0,0,0,0,0,1,0,0);
        c_mwr  = cw(0,0,1,2'b00,0,2'b00,2'b00, 0,1,0,0,0,0,0,0);
        c_mwto = cw(0,0,1,2'b00,0,2'b00,2'b00, 0,0,0,0,0,0,0,1);
        c_exe  = cw(0,0,0,2'b00,1,2'b00,2'b10, 0,0,0,0,0,0,0,0);
        c_awb  = cw(0,1,0,2'b00,0,2'b00,2'b00, 0,0,0,0,0,1,0,0);
        c_br   = cw(0,0,0,2'b01,1,2'b00,2'b01, 0,0,0,1,0,0,0,0);
        c_bn   = cw(0,0,0,2'b01,1,2'b00,2'b01, 0,0,0,0,1,0,0,0);
        c_ae   = cw(0,0,0,2'b00,1,2'b10,2'b00, 0,0,0,0,0,0,0,0);
        c_aw   = cw(0,0,0,2'b00,0,2'b00,2'b00, 0,0,0,0,0,1,0,0);
        c_j    = cw(0,0,0,2'b10,0,2'b00,2'b00, 0,0,1,0,0,0,0,0);

        // reset held low: FETCH, enables forced off even with memready=1
        add(0, RT, 1, 0, c_f0);
        // R-type, with reset hitting EXECUTE
        add(1, RT, 1, 0, c_fr);  add(1, RT, 1, 1, c_dec);  add(1, RT, 1, 6, c_exe);
        add(0, RT, 1, 0, c_f0);
        add(1, RT, 1, 0, c_fr);  add(1, RT, 1, 1, c_dec);  add(1, RT, 1, 6, c_exe);
        add(1, RT, 1, 7, c_awb);
        // lw: one fetch stall, then three MEMRD stalls
        add(1, LW, 0, 0, c_f0);  add(1, LW, 1, 0, c_fr);   add(1, LW, 1, 1, c_dec);
        add(1, LW, 1, 2, c_ma);
        add(1, LW, 0, 3, c_mrd); add(1, LW, 0, 3, c_mrd);  add(1, LW, 0, 3, c_mrd);
        add(1, LW, 1, 3, c_mrd); add(1, LW, 1, 4, c_mwb);
        // sw with zero wait
        add(1, SW, 1, 0, c_fr);  add(1, SW, 1, 1, c_dec);  add(1, SW, 1, 2, c_ma);
        add(1, SW, 1, 5, c_mwr);
        // beq, j, addi
        add(1, BEQ, 1, 0, c_fr); add(1, BEQ, 1, 1, c_dec); add(1, BEQ, 1, 8, c_br);
        add(1, JMP, 1, 0, c_fr); add(1, JMP, 1, 1, c_dec); add(1, JMP, 1, 11, c_j);
        add(1, ADI, 1, 0, c_fr); add(1, ADI, 1, 1, c_dec); add(1, ADI, 1, 9, c_ae);
        add(1, ADI, 1, 10, c_aw);
        // illegal opcode: pulse in DECODE, back to FETCH with no enables
        add(1, ILL, 1, 0, c_fr); add(1, ILL, 1, 1, c_deci); add(1, ILL, 0, 0, c_f0);
        // bne: depends on the build option
        add(1, BNE, 1, 0, c_fr);
`ifdef MAINFSM_BNE_EN
        add(1, BNE, 1, 1, c_dec); add(1, BNE, 1, 8, c_bn);
`else
        add(1, BNE, 1, 1, c_deci); add(1, BNE, 0, 0, c_f0);
`endif
        // sw: timeout on the 4th stalled MEMWR cycle, memwrite gated off
        add(1, SW, 1, 0, c_fr);  add(1, SW, 1, 1, c_dec);  add(1, SW, 1, 2, c_ma);
        add(1, SW, 0, 5, c_mwr); add(1, SW, 0, 5, c_mwr);  add(1, SW, 0, 5, c_mwr);
        add(1, SW, 0, 5, c_mwto);
        // fetch: counter restarts, memready on the limit cycle wins
        add(1, SW, 0, 0, c_f0);  add(1, SW, 0, 0, c_f0);   add(1, SW, 0, 0, c_f0);
        add(1, SW, 1, 0, c_fr);  add(1, SW, 1, 1, c_dec);  add(1, SW, 1, 2, c_ma);
        // MEMWR: memready on the limit cycle completes the store
        add(1, SW, 0, 5, c_mwr); add(1, SW, 0, 5, c_mwr);  add(1, SW, 0, 5, c_mwr);
        add(1, SW, 1, 5, c_mwr);
        // fetch timeout, then the counter is clear again
        add(1, SW, 0, 0, c_f0);  add(1, SW, 0, 0, c_f0);   add(1, SW, 0, 0, c_f0);
        add(1, SW, 0, 0, c_fto); add(1, SW, 0, 0, c_f0);   add(1, SW, 1, 0, c_fr);

        // ---------------- driver: table loop ----------------
        foreach (vecs[i]) begin
            @(negedge clk);
            reset    = vecs[i].rst;
            op       = vecs[i].op;
            memready = vecs[i].mr;
            #1;
            chk($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
            chk($sformatf("vec%0d_ctl", i), 32'(act_ctl), 32'(vecs[i].ctl));
        end

        // ---------------- async reset in the middle of a store ----------------
        @(negedge clk);
        reset = 1'b0; memready = 1'b1; op = SW;
        #1;
        chk("rst_state", 32'(state), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        begin
            int n;
            n = 0;
            while (state != 4'd2 && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk("reach_memadr", 32'(state), 32'd2);
        end
        memready = 1'b0;
        @(negedge clk);
        #1;
        chk("sw_wait_state", 32'(state), 32'd5);
        chk("sw_wait_memwrite", 32'(memwrite), 32'd1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("midcycle_rst_state", 32'(state), 32'd0);
        chk("midcycle_rst_ctl", 32'(act_ctl), 32'(c_f0));
        @(posedge clk);
        #1;
        chk("rst_hold_state", 32'(state), 32'd0);
        @(negedge clk);
        reset    = 1'b1;
        memready = 1'b1;
        #1;
        chk("release_ctl", 32'(act_ctl), 32'(c_fr));
        @(posedge clk);
        #1;
        chk("release_state", 32'(state), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
